ahb_lite_master_if: RTL and testbench

Single-port AHB-Lite initiator that turns a simple valid/ready command stream into AHB-Lite single transfers. It returns one in-order response per command. It drives the master side of the AHB node that fans out to the memory slaves, letting cores, DMA engines and testbench stimulus issue bus traffic without handling AHB pipelining. Address and data phases overlap, giving one transfer per cycle with zero-wait slaves.

---
 rtl/ahb_lite_master_if.sv | 167 ++++++++++++++++
 tb/tb_ahb_lite_master_if.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if
// Single-port AHB-Lite initiator. A valid/ready command stream is turned into
// AHB-Lite SINGLE transfers using a two-stage pipeline: the address-phase
// (AP) register drives HADDR/HTRANS/HWRITE/HSIZE, and the data-phase (DP)
// register drives HWDATA and tracks the transfer whose response is pending.
// Exactly one in-order response pulse is produced per accepted command.

module ahb_lite_master_if #(
  parameter int          AHB_ADDR_WIDTH = 32,
  parameter int          AHB_DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
  input  logic                      clk,
  input  logic                      rst,
  // command side
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AHB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]                cmd_size,
  input  logic [AHB_DATA_WIDTH-1:0] cmd_wdata,
  // response side
  output logic                      rsp_valid,
  output logic [AHB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  // AHB-Lite master side
  output logic [AHB_ADDR_WIDTH-1:0] haddr,
  output logic [1:0]                htrans,
  output logic                      hwrite,
  output logic [2:0]                hsize,
  output logic [2:0]                hburst,
  output logic [3:0]                hprot,
  output logic                      hmastlock,
  output logic [AHB_DATA_WIDTH-1:0] hwdata,
  input  logic [AHB_DATA_WIDTH-1:0] hrdata,
  input  logic                      hready,
  input  logic                      hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Force the low 'sz' address bits to zero so every transfer is size-aligned.
  function automatic logic [AHB_ADDR_WIDTH-1:0] align_addr(
    input logic [AHB_ADDR_WIDTH-1:0] a,
    input logic [2:0]                sz
  );
    logic [AHB_ADDR_WIDTH-1:0] r;
    r = a;
    for (int i = 0; i < 7; i++) begin
      if (i < AHB_ADDR_WIDTH) begin
        r[i] = (i < int'(sz)) ? 1'b0 : a[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Read data is returned only for reads; writes report all-zero data.
  function automatic logic [AHB_DATA_WIDTH-1:0] select_rdata(
    input logic                      was_write,
    input logic [AHB_DATA_WIDTH-1:0] rd
  );
    return was_write ? {AHB_DATA_WIDTH{1'b0}} : rd;
  endfunction

  // address-phase stage
  logic                      ap_vld_r;
  logic [AHB_ADDR_WIDTH-1:0] ap_addr_r;
  logic                      ap_write_r;
  logic [2:0]                ap_size_r;
  logic [AHB_DATA_WIDTH-1:0] ap_wdata_r;

  // data-phase stage
  logic                      dp_vld_r;
  logic                      dp_write_r;
  logic [AHB_DATA_WIDTH-1:0] dp_wdata_r;

  // response registers
  logic                      rsp_valid_r;
  logic [AHB_DATA_WIDTH-1:0] rsp_rdata_r;
  logic                      rsp_err_r;

  logic                      accept_s;
  logic                      complete_s;

  // The AP slot can take a command when empty, or when its current occupant
  // is moving into the data phase on this edge.
  assign cmd_ready  = ~ap_vld_r | hready;
  assign accept_s   = cmd_valid & cmd_ready;
  assign complete_s = dp_vld_r & hready;

  // Address-phase register: load on accept, drain into DP when HREADY is high,
  // otherwise hold so HADDR/HWRITE/HSIZE stay stable through wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      ap_vld_r   <= 1'b0;
      ap_addr_r  <= {AHB_ADDR_WIDTH{1'b0}};
      ap_write_r <= 1'b0;
      ap_size_r  <= HSIZE_WORD;
      ap_wdata_r <= {AHB_DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      ap_vld_r   <= 1'b1;
      ap_addr_r  <= align_addr(cmd_addr, cmd_size);
      ap_write_r <= cmd_write;
      ap_size_r  <= cmd_size;
      ap_wdata_r <= cmd_wdata;
    end else if (hready) begin
      ap_vld_r   <= 1'b0;
    end else begin
      ap_vld_r   <= ap_vld_r;
    end
  end

  // Data-phase register: takes the AP contents when the address phase
  // completes; HWDATA keeps its last value once the data phase is over.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_vld_r   <= 1'b0;
      dp_write_r <= 1'b0;
      dp_wdata_r <= {AHB_DATA_WIDTH{1'b0}};
    end else if (hready && ap_vld_r) begin
      dp_vld_r   <= 1'b1;
      dp_write_r <= ap_write_r;
      dp_wdata_r <= ap_wdata_r;
    end else if (hready) begin
      dp_vld_r   <= 1'b0;
    end else begin
      dp_vld_r   <= dp_vld_r;
    end
  end

  // Response register: one-cycle pulse after each completed data phase,
  // capturing HRESP and (for reads) HRDATA; data/error hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {AHB_DATA_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (complete_s) begin
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= select_rdata(dp_write_r, hrdata);
      rsp_err_r   <= hresp;
    end else begin
      rsp_valid_r <= 1'b0;
    end
  end

  // bus outputs come straight from the stage registers
  assign haddr     = ap_addr_r;
  assign htrans    = ap_vld_r ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite    = ap_write_r;
  assign hsize     = ap_size_r;
  assign hburst    = 3'b000;
  assign hprot     = HPROT_VAL;
  assign hmastlock = 1'b0;
  assign hwdata    = dp_wdata_r;

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = ap_vld_r | dp_vld_r;

endmodule

// File: tb/tb_ahb_lite_master_if.sv
// Self-checking bench for ahb_lite_master_if: behavioural AHB slave with
// address-dependent wait states / ERROR responses, and a response scoreboard.

module tb_ahb_lite_master_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  ahb_lite_master_if #(
    .AHB_ADDR_WIDTH(32),
    .AHB_DATA_WIDTH(32),
    .HPROT_VAL(4'b0011)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [31:0] smem [64];
  logic        s_act;
  logic        s_write;
  logic        s_err;
  logic [31:0] s_addr;
  logic [2:0]  s_cnt;

  function automatic logic [2:0] slave_waits(input logic [31:0] a);
    if (a == 32'h0000_0020) return 3'd3;
    else if (a == 32'h0000_0040) return 3'd4;
    else return 3'd0;
  endfunction

  assign hready = ~s_act | (s_cnt == 3'd0);
  assign hresp  = s_act & s_err;
  assign hrdata = (s_act && !s_write) ? smem[s_addr[7:2]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (rst) begin
      s_act   <= 1'b0;
      s_write <= 1'b0;
      s_err   <= 1'b0;
      s_addr  <= 32'h0;
      s_cnt   <= 3'd0;
      for (int i = 0; i < 64; i++) smem[i] <= 32'h0;
    end else if (hready) begin
      if (s_act && s_write && !s_err) smem[s_addr[7:2]] <= hwdata;
      if (htrans == 2'b10) begin
        s_act   <= 1'b1;
        s_addr  <= haddr;
        s_write <= hwrite;
        s_err   <= (haddr[31:28] == 4'h3);
        s_cnt   <= (haddr[31:28] == 4'h3) ? 3'd1 : slave_waits(haddr);
      end else begin
        s_act   <= 1'b0;
      end
    end else begin
      s_cnt <= s_cnt - 3'd1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] refm [64];

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("rsp_rdata", rsp_rdata, e.rdata);
        check_val("rsp_err", rsp_err, e.err);
        if (e.lat >= 0) check_val("rsp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  // Drive one command starting at a negedge; returns at the negedge after the
  // accepting edge, with the command still on the inputs.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wd, input int lat);
    int   waited;
    exp_t e;
    logic [31:0] al;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = sz;
    cmd_wdata = wd;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check_val("ready_timeout", 64'd0, 64'd1);
    end else begin
      al = addr;
      for (int i = 0; i < 7; i++) if (i < int'(sz)) al[i] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      e.err   = (al[31:28] == 4'h3);
      e.rdata = wr ? 32'h0 : refm[al[7:2]];
      e.acc   = cyc;
      e.lat   = lat;
      if (wr && !e.err) refm[al[7:2]] = wd;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, sb.size(), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) refm[i] = 32'h0;
    rst = 1'b1;
    idle();
    cmd_addr  = 32'h0;
    cmd_size  = 3'd2;
    cmd_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check_val("rst_htrans", htrans, 2'b00);
    check_val("rst_haddr", haddr, 32'h0);
    check_val("rst_hwrite", hwrite, 1'b0);
    check_val("rst_hsize", hsize, 3'b010);
    check_val("rst_hwdata", hwdata, 32'h0);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_val("rst_rsp_err", rsp_err, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_cmd_ready", cmd_ready, 1'b1);
    check_val("hburst", hburst, 3'b000);
    check_val("hprot", hprot, 4'b0011);
    check_val("hmastlock", hmastlock, 1'b0);

    // write then read back, zero-wait
    send(1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 2);
    check_val("t1_htrans", htrans, 2'b10);
    check_val("t1_haddr", haddr, 32'h10);
    check_val("t1_hwrite", hwrite, 1'b1);
    send(1'b0, 32'h0000_0010, 3'd2, 32'h0, 2);
    check_val("t1_hwdata", hwdata, 32'hDEAD_BEEF);
    check_val("t1_rd_hwrite", hwrite, 1'b0);
    idle();
    drain("t1_drain");

    // 8 back-to-back writes
    for (int i = 0; i < 8; i++) begin
      check_val("b2b_ready", cmd_ready, 1'b1);
      send(1'b1, 32'(i * 4), 3'd2, 32'h1000_0000 + 32'(i), 2);
      check_val("b2b_htrans", htrans, 2'b10);
      check_val("b2b_haddr", haddr, 32'(i * 4));
    end
    idle();
    repeat (2) @(negedge clk);
    check_val("b2b_idle_htrans", htrans, 2'b00);
    check_val("b2b_idle_busy", busy, 1'b0);
    drain("b2b_drain");

    // 3 wait states on read of 0x20, second command queued behind it
    send(1'b0, 32'h0000_0020, 3'd2, 32'h0, 5);
    send(1'b0, 32'h0000_0024, 3'd2, 32'h0, 5);
    idle();
    for (int i = 0; i < 3; i++) begin
      check_val("wait_haddr", haddr, 32'h24);
      check_val("wait_htrans", htrans, 2'b10);
      check_val("wait_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
    end
    drain("wait_drain");

    // two-cycle ERROR on a write, read still completes
    send(1'b1, 32'h3000_0000, 3'd2, 32'h5555_AAAA, 3);
    send(1'b0, 32'h0000_0004, 3'd2, 32'h0, 3);
    idle();
    drain("err_drain");

    // address alignment
    send(1'b0, 32'h0000_0013, 3'd1, 32'h0, 2);
    check_val("align_h1", haddr, 32'h12);
    check_val("align_hsize1", hsize, 3'd1);
    send(1'b0, 32'h0000_0013, 3'd2, 32'h0, 2);
    check_val("align_w", haddr, 32'h10);
    idle();
    drain("align_drain");

    // reset during a waited data phase
    send(1'b0, 32'h0000_0040, 3'd2, 32'h0, -1);
    idle();
    @(negedge clk);
    check_val("abort_hready_low", hready, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_val("abort_htrans", htrans, 2'b00);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_rsp_valid", rsp_valid, 1'b0);
    check_val("abort_cmd_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) refm[i] = 32'h0;
    repeat (6) @(negedge clk);
    send(1'b1, 32'h0000_0008, 3'd2, 32'hCAFE_F00D, 2);
    send(1'b0, 32'h0000_0008, 3'd2, 32'h0, 2);
    idle();
    drain("post_rst_drain");
    check_val("post_rst_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
